// File: rtl/masked_nn_pkg.sv
// Shared types and helpers for the masked neural-network layers.
// State encoding, index-width helper and default layer dimensions.
package masked_nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_FIN,
    ST_OUT
  } state_e;

  localparam int unsigned DEF_WIDTH       = 16;
  localparam int unsigned DEF_INPUT_SIZE  = 10;
  localparam int unsigned DEF_OUTPUT_SIZE = 10;
  localparam int unsigned DEF_LANES       = 1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/masked_mac_lane.sv
// One share's LANES-wide multiply-accumulate; instantiated once per share so
// the two share datapaths never meet.
module masked_mac_lane #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] x_lanes,
  input  logic [LANES*WIDTH-1:0] w_lanes,
  output logic [WIDTH-1:0]       acc
);

  logic [WIDTH-1:0] acc_q, acc_d;

  // Modular WIDTH-bit products and sums; no saturation.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        acc_d = acc_d + x_lanes[l*WIDTH +: WIDTH] * w_lanes[l*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/masked_dense_layer_seq.sv
// Time-multiplexed dense layer on first-order arithmetic-masked activations.
// Optional share refresh on output under macro MASKED_LAYER_REFRESH_EN.
module masked_dense_layer_seq
  import masked_nn_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int unsigned OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned LANES       = DEF_LANES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [INPUT_SIZE*WIDTH-1:0]           in_sh0,
  input  logic [INPUT_SIZE*WIDTH-1:0]           in_sh1,
  input  logic [OUTPUT_SIZE*INPUT_SIZE*WIDTH-1:0] weights,
  input  logic [OUTPUT_SIZE*WIDTH-1:0]          bias,
  input  logic [WIDTH-1:0]                      rnd,
  output logic                                  busy,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [clog2_min1(OUTPUT_SIZE)-1:0]    out_idx,
  output logic [WIDTH-1:0]                      out_sh0,
  output logic [WIDTH-1:0]                      out_sh1,
  output logic                                  done
);

  localparam int unsigned K     = INPUT_SIZE / LANES;
  localparam int unsigned IDX_W = clog2_min1(OUTPUT_SIZE);
  localparam int unsigned K_W   = clog2_min1(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(K - 1);

  state_e state_q, state_d;
  logic [INPUT_SIZE*WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [IDX_W-1:0] n_q, n_d, out_idx_q, out_idx_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] out_sh0_q, out_sh0_d, out_sh1_q, out_sh1_d;
  logic busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;

  logic acc_clr, acc_en;
  logic [WIDTH-1:0] acc0, acc1, bias_n;
  logic [LANES*WIDTH-1:0] x0_lanes, x1_lanes, w_lanes;

  // Operand selection as an explicit compare-mux over all (n, i) pairs.
  always_comb begin
    int unsigned n_i, k_i;
    n_i      = 32'(n_q);
    k_i      = 32'(k_q);
    x0_lanes = '0;
    x1_lanes = '0;
    w_lanes  = '0;
    bias_n   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
        if (i == k_i * LANES + l) begin
          x0_lanes[l*WIDTH +: WIDTH] = x0_q[i*WIDTH +: WIDTH];
          x1_lanes[l*WIDTH +: WIDTH] = x1_q[i*WIDTH +: WIDTH];
          for (int unsigned n = 0; n < OUTPUT_SIZE; n++) begin
            if (n == n_i) w_lanes[l*WIDTH +: WIDTH] = weights[(n*INPUT_SIZE+i)*WIDTH +: WIDTH];
          end
        end
      end
    end
    for (int unsigned n = 0; n < OUTPUT_SIZE; n++) begin
      if (n == n_i) bias_n = bias[n*WIDTH +: WIDTH];
    end
  end

  masked_mac_lane #(.WIDTH(WIDTH), .LANES(LANES)) u_lane0 (
    .clk(clk), .rst(rst), .clr(acc_clr), .en(acc_en),
    .x_lanes(x0_lanes), .w_lanes(w_lanes), .acc(acc0)
  );

  masked_mac_lane #(.WIDTH(WIDTH), .LANES(LANES)) u_lane1 (
    .clk(clk), .rst(rst), .clr(acc_clr), .en(acc_en),
    .x_lanes(x1_lanes), .w_lanes(w_lanes), .acc(acc1)
  );

`ifndef MASKED_LAYER_REFRESH_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd;
`endif

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    n_d         = n_q;
    k_d         = k_q;
    out_idx_d   = out_idx_q;
    out_sh0_d   = out_sh0_q;
    out_sh1_d   = out_sh1_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q marks the pulse cycle; a start there is dropped.
        if (start && !done_q) begin
          x0_d    = in_sh0;
          x1_d    = in_sh1;
          n_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_en = 1'b1;
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = ST_FIN;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ST_FIN: begin
`ifdef MASKED_LAYER_REFRESH_EN
        out_sh0_d = acc0 + bias_n + rnd;
        out_sh1_d = acc1 - rnd;
`else
        out_sh0_d = acc0 + bias_n;
        out_sh1_d = acc1;
`endif
        out_idx_d   = n_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (n_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            n_d     = n_q + IDX_W'(1);
            k_d     = '0;
            acc_clr = 1'b1;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      n_q         <= '0;
      k_q         <= '0;
      out_idx_q   <= '0;
      out_sh0_q   <= '0;
      out_sh1_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      n_q         <= n_d;
      k_q         <= k_d;
      out_idx_q   <= out_idx_d;
      out_sh0_q   <= out_sh0_d;
      out_sh1_q   <= out_sh1_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_sh0   = out_sh0_q;
  assign out_sh1   = out_sh1_q;
  assign done      = done_q;

endmodule

// File: tb/tb_masked_dense_layer_seq.sv
// Self-checking bench for masked_dense_layer_seq: vector table plus scoreboard,
// with hand-written reset-abort and LANES=2 sequences.
module tb_masked_dense_layer_seq;

  localparam int unsigned IS = 4;
  localparam int unsigned OS = 2;
  localparam int unsigned W  = 16;
  localparam logic [W-1:0] RNDV = 16'hA5A5;

  typedef logic [3:0][15:0] w4_t;
  typedef struct packed {
    w4_t                   x;
    w4_t                   s0;
    logic [1:0][3:0][15:0] w;
    logic [1:0][15:0]      b;
    logic [1:0][15:0]      exp_sum;
    logic [3:0]            stall;
  } vec_t;

  typedef struct packed {
    logic [0:0]  idx;
    logic [15:0] sh0;
    logic [15:0] sh1;
    logic [15:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start2 = 1'b0, out_ready = 1'b0, out_ready2 = 1'b1;
  logic [IS*W-1:0] in_sh0 = '0, in_sh1 = '0;
  logic [OS*IS*W-1:0] weights = '0;
  logic [OS*W-1:0] bias = '0;
  logic [W-1:0] rnd = RNDV;

  logic busy, out_valid, done, busy2, out_valid2, done2;
  logic [0:0] out_idx, out_idx2;
  logic [W-1:0] out_sh0, out_sh1, out_sh0_2, out_sh1_2;

  int checks = 0;
  int errors = 0;
  vec_t vecs[4];
  exp_t sb[$];

  always #5 clk = ~clk;

  masked_dense_layer_seq #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WIDTH(W), .LANES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in_sh0(in_sh0), .in_sh1(in_sh1),
    .weights(weights), .bias(bias), .rnd(rnd), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_sh0(out_sh0), .out_sh1(out_sh1),
    .done(done)
  );

  masked_dense_layer_seq #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .WIDTH(W), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_sh0(in_sh0), .in_sh1(in_sh1),
    .weights(weights), .bias(bias), .rnd(rnd), .busy(busy2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_idx(out_idx2), .out_sh0(out_sh0_2), .out_sh1(out_sh1_2),
    .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic w4_t mk4(input logic [15:0] a, b, c, d);
    w4_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Drive buses for a vector and push the per-share reference results.
  task automatic load(input int vi);
    vec_t v;
    exp_t e;
    logic [15:0] a0, a1, s1;
    v = vecs[vi];
    for (int i = 0; i < 4; i++) begin
      in_sh0[i*W +: W] = v.s0[i];
      in_sh1[i*W +: W] = v.x[i] - v.s0[i];
    end
    weights = v.w;
    bias    = v.b;
    for (int n = 0; n < 2; n++) begin
      a0 = '0;
      a1 = '0;
      for (int i = 0; i < 4; i++) begin
        s1 = v.x[i] - v.s0[i];
        a0 = a0 + v.s0[i] * v.w[n][i];
        a1 = a1 + s1 * v.w[n][i];
      end
      e.idx = n[0];
`ifdef MASKED_LAYER_REFRESH_EN
      e.sh0 = a0 + v.b[n] + RNDV;
      e.sh1 = a1 - RNDV;
`else
      e.sh0 = a0 + v.b[n];
      e.sh1 = a1;
`endif
      e.sum = v.exp_sum[n];
      sb.push_back(e);
    end
  endtask

  task automatic cmp_out(input string tag, input logic [0:0] idx,
                         input logic [15:0] s0, input logic [15:0] s1);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty actual=output required=none", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_idx"}, 32'(idx), 32'(e.idx));
      check({tag, "_sh0"}, 32'(s0), 32'(e.sh0));
      check({tag, "_sh1"}, 32'(s1), 32'(e.sh1));
      check({tag, "_sum"}, 32'(16'(s0 + s1)), 32'(e.sum));
    end
  endtask

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid required=valid", tag);
    end
  endtask

  task automatic run_layer(input int vi, input bit poke);
    int lat;
    int unsigned stall;
    logic [32:0] held;
    stall = 32'(vecs[vi].stall);
    load(vi);
    out_ready = (stall == 0);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    in_sh0 = {$urandom, $urandom};
    in_sh1 = {$urandom, $urandom};
    for (int n = 0; n < 2; n++) begin
      wait_valid($sformatf("v%0d_n%0d", vi, n), lat);
      check($sformatf("v%0d_n%0d_latency", vi, n), 32'(lat), 32'd5);
      cmp_out($sformatf("v%0d_n%0d", vi, n), out_idx, out_sh0, out_sh1);
      held = {out_valid, out_idx, out_sh0 ^ {out_sh1[7:0], out_sh1[15:8]}};
      for (int unsigned s = 0; s < stall; s++) begin
        if (poke && s == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_n%0d_hold%0d", vi, n, s),
              {out_valid, out_idx, out_sh0 ^ {out_sh1[7:0], out_sh1[15:8]}}, held);
        check($sformatf("v%0d_n%0d_nodone%0d", vi, n, s), 32'(done), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = (stall == 0);
      check($sformatf("v%0d_n%0d_drop", vi, n), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_n%0d_done", vi, n), 32'(done), 32'(n == 1));
      check($sformatf("v%0d_n%0d_busy", vi, n), 32'(busy), 32'(n != 1));
    end
    // Start coinciding with the done pulse must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_done_pulse_end", vi), 32'(done), 32'd0);
    check($sformatf("v%0d_start_on_done_ignored", vi), 32'(busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_idle_after", vi), {31'd0, busy | out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0].x = mk4(16'd1, 16'd2, 16'd3, 16'd4);
    vecs[0].s0 = mk4(16'h1234, 16'hFFFF, 16'h0007, 16'h8000);
    vecs[0].w[0] = mk4(16'd1, 16'd1, 16'd1, 16'd1);
    vecs[0].w[1] = mk4(16'd2, 16'd0, 16'd0, 16'hFFFF);
    vecs[0].b[0] = 16'd5;
    vecs[0].b[1] = 16'd0;
    vecs[0].exp_sum[0] = 16'd15;
    vecs[0].exp_sum[1] = 16'hFFFE;
    vecs[0].stall = 4'd0;

    vecs[1] = vecs[0];
    vecs[1].stall = 4'd3;

    vecs[2].x = mk4(16'h7FFF, 16'h0000, 16'h0000, 16'h0000);
    vecs[2].s0 = mk4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    vecs[2].w[0] = mk4(16'd2, 16'd0, 16'd0, 16'd0);
    vecs[2].w[1] = mk4(16'h8000, 16'd1, 16'd0, 16'd0);
    vecs[2].b[0] = 16'd3;
    vecs[2].b[1] = 16'h0010;
    vecs[2].exp_sum[0] = 16'h0001;
    vecs[2].exp_sum[1] = 16'h8010;
    vecs[2].stall = 4'd0;

    vecs[3].x = mk4(16'h0100, 16'hFFFE, 16'h0003, 16'h1000);
    vecs[3].s0 = mk4(16'hAAAA, 16'h5555, 16'hFFFF, 16'h0001);
    vecs[3].w[0] = mk4(16'd3, 16'd2, 16'hFFFF, 16'h0010);
    vecs[3].w[1] = mk4(16'h0010, 16'h0100, 16'h1000, 16'hFFFF);
    vecs[3].b[0] = 16'h0100;
    vecs[3].b[1] = 16'hFFFF;
    vecs[3].exp_sum[0] = 16'h03F9;
    vecs[3].exp_sum[1] = 16'h2DFF;
    vecs[3].stall = 4'd1;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_sh0", 32'(out_sh0), 32'd0);
    check("rst_sh1", 32'(out_sh1), 32'd0);
    check("rst2_busy_valid", {30'd0, busy2, out_valid2}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int vi = 0; vi < 4; vi++) begin
      run_layer(vi, vi == 1);
    end

    // Reset in the middle of neuron 1 accumulation.
    load(0);
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("rstseq", lat);
    @(negedge clk);
    @(negedge clk);
    check("rstseq_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstseq_busy", 32'(busy), 32'd0);
    check("rstseq_valid", 32'(out_valid), 32'd0);
    check("rstseq_outs", {out_idx, out_sh0[14:0], out_sh1}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid | done | busy;
    end
    check("rstseq_no_partial", 32'(seen), 32'd0);
    run_layer(0, 1'b0);

    // LANES=2 instance: K=2, so first output after 3 edges.
    load(0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 2; n++) begin
      lat = 0;
      while (!out_valid2 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("l2_n%0d_latency", n), 32'(lat), 32'd3);
      cmp_out($sformatf("l2_n%0d", n), out_idx2, out_sh0_2, out_sh1_2);
      @(negedge clk);
      check($sformatf("l2_n%0d_done", n), 32'(done2), 32'(n == 1));
    end
    @(negedge clk);
    check("l2_idle", {30'd0, busy2, done2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/masked_dense_layer_seq.md
Name: masked_dense_layer_seq

Overview:
- Time-multiplexed, parametrised dense (fully-connected) layer operating on first-order arithmetic-masked activations.
- Each input activation arrives as two shares: x = x_sh0 + x_sh1 mod 2^WIDTH.
- Each neuron's weighted sum plus bias is computed share-wise, so the unmasked value never exists in the datapath.
- It replaces the combinational per-layer instances in the network top. Layers chain through the output stream.

Parameters:
- INPUT_SIZE, 10, number of input activations per neuron; must be a multiple of LANES
- OUTPUT_SIZE, 10, number of neurons computed per start
- WIDTH, 16, activation/weight/bias/share width; all arithmetic is mod 2^WIDTH
- LANES, 1, multiply-accumulates per share per cycle

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a layer evaluation; sampled only in IDLE
- in_sh0  in  INPUT_SIZE*WIDTH  share 0 of inputs; element i at [i*WIDTH +: WIDTH]
- in_sh1  in  INPUT_SIZE*WIDTH  share 1 of inputs, same packing
- weights  in  OUTPUT_SIZE*INPUT_SIZE*WIDTH  element (n,i) at [(n*INPUT_SIZE+i)*WIDTH +: WIDTH]; must be stable while busy
- bias  in  OUTPUT_SIZE*WIDTH  bias of neuron n at [n*WIDTH +: WIDTH]; must be stable while busy
- rnd  in  WIDTH  fresh randomness, used only with the optional feature
- busy  out  1  high from start acceptance until done
- out_valid  out  1  output share pair valid
- out_ready  in  1  downstream accepts the output
- out_idx  out  clog2(OUTPUT_SIZE) (min 1)  neuron index of the current output
- out_sh0  out  WIDTH  share 0 of the neuron result
- out_sh1  out  WIDTH  share 1 of the neuron result
- done  out  1  single-cycle pulse after the last output handshake

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy, out_valid, done, out_idx, out_sh0, out_sh1, both accumulators and captured inputs all go to 0.
  - Reset asserted mid-operation aborts the evaluation; no partial output appears after reset release.
- States:
  - IDLE: start=1 → capture in_sh0/in_sh1 into internal registers, neuron n=0, clear acc0/acc1, chunk k=0, busy=1 → MAC. Inputs may change afterwards.
  - MAC: each cycle, for lanes l in 0..LANES-1, with i = k*LANES+l:
    - acc0 += x_sh0[i]*w[n][i]
    - acc1 += x_sh1[i]*w[n][i]
    - Products and sums are truncated to WIDTH bits (modular, signed two's complement; no saturation, since saturation breaks masking).
    - After K = INPUT_SIZE/LANES cycles → FIN.
  - FIN (1 cycle):
    - out_sh0 <= acc0 + bias[n]; out_sh1 <= acc1; out_idx <= n; out_valid <= 1 → OUT.
  - OUT:
    - Outputs are held stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready:
      - If n < OUTPUT_SIZE-1: out_valid <= 0, n++, clear accumulators, k=0 → MAC.
      - Else: out_valid <= 0, busy <= 0, done <= 1 for one cycle → IDLE.
- Latency: start sampled at edge t → first out_valid after edge t+K+1. Per-neuron throughput is K+2 cycles with out_ready tied high.
- start while busy is ignored. start in the same cycle as the done pulse is also ignored; it is accepted on the next cycle.
- Correctness invariant: out_sh0 + out_sh1 mod 2^WIDTH = bias[n] + sum_i x[i]*w[n][i] mod 2^WIDTH.
- Shares must never be combined in any register or adder. acc0 and acc1 use physically separate datapaths.

Optional Feature:
- Macro MASKED_LAYER_REFRESH_EN.
- Defined: in FIN, out_sh0 <= acc0 + bias[n] + rnd and out_sh1 <= acc1 - rnd. rnd is sampled in the FIN cycle, and the unmasked sum is unchanged.
- Undefined: rnd is unused and FIN behaves as specified above.

Decomposition:
- Package masked_nn_pkg holds:
  - state enum (IDLE, MAC, FIN, OUT)
  - function clog2_min1
  - localparam-derived widths shared across layers
- Sub-module masked_mac_lane: one share's LANES-wide multiply-accumulate. It is instantiated twice (share 0, share 1) to enforce datapath separation.

Test Plan:
- INPUT_SIZE=4, OUTPUT_SIZE=2, WIDTH=16, LANES=1. x=[1,2,3,4] as sh0=[0x1234,0xFFFF,0x0007,0x8000], sh1=x-sh0. w0=[1,1,1,1], b0=5; w1=[2,0,0,-1], b1=0. Expect idx0 sum 15, idx1 sum -2 (0xFFFE), first out_valid 5 cycles after start, then done pulse.
- Same run with out_ready low for 3 cycles at each output → outputs held stable, each result accepted once, done after the second handshake only.
- LANES=2 → first out_valid 3 cycles after start, same sums as the first scenario.
- Overflow: x=0x7FFF, w=2 (INPUT_SIZE=1), b=3 → sum 0x0001 (wraps, no saturation).
- rst asserted in MAC of neuron 1 → busy, out_valid, outputs 0 immediately. A fresh start afterwards gives correct sums.
- With MASKED_LAYER_REFRESH_EN, rnd=0xA5A5 → out_sh0 differs from the non-refresh run by 0xA5A5, and the share sum is unchanged. start pulsed while busy → ignored.
